// File: rtl/cv32e41s_rpm_responder_if.sv
// RPM responder bus bundle: walker implicit-read port, M-mode programming
// write port, scrub control and status. The responder uses the slave modport;
// the walker/programming side uses master.
interface cv32e41s_rpm_responder_if #(
  parameter int DEPTH = 64
);
  localparam int IDX_W = $clog2(DEPTH);

  // Walker implicit-read port
  logic             imp_req_i;
  logic [31:0]      imp_addr_i;
  logic             imp_rvalid_o;
  logic [31:0]      imp_rdata_b0_o;
  logic [31:0]      imp_rdata_b1_o;
  logic             imp_addr_err_o;

  // Programming write port
  logic             wr_req_i;
  logic             wr_gnt_o;
  logic [IDX_W-1:0] wr_idx_i;
  logic             wr_bank_i;
  logic [31:0]      wr_data_i;

  // Scrub control and status
  logic             scrub_req_i;
  logic             busy_o;
  logic             parity_err_o;
  logic             dbg_state_o;  // 0 = SCRUB, 1 = READY

  // Handshake rules:
  //   read  : imp_req_i may stay high; each cycle it is high in READY the
  //           index is captured and imp_rvalid_o pulses exactly one cycle
  //           later with the data. There is no backpressure on reads.
  //   write : a write is transferred in any cycle where wr_req_i and
  //           wr_gnt_o are both high; wr_gnt_o is combinational and only
  //           ever high in READY.
  modport slave (
    input  imp_req_i, imp_addr_i, wr_req_i, wr_idx_i, wr_bank_i, wr_data_i,
           scrub_req_i,
    output imp_rvalid_o, imp_rdata_b0_o, imp_rdata_b1_o, imp_addr_err_o,
           wr_gnt_o, busy_o, parity_err_o, dbg_state_o
  );

  modport master (
    output imp_req_i, imp_addr_i, wr_req_i, wr_idx_i, wr_bank_i, wr_data_i,
           scrub_req_i,
    input  imp_rvalid_o, imp_rdata_b0_o, imp_rdata_b1_o, imp_addr_err_o,
           wr_gnt_o, busy_o, parity_err_o, dbg_state_o
  );
endinterface

// File: rtl/cv32e41s_rpm_responder.sv
// Region Protection Memory responder. DEPTH two-word entries (bank 0 =
// CTRL/CFG, bank 1 = GUARD/ADDROFF), one-cycle walker reads with write-first
// forwarding, M-mode programming writes, and a full zero scrub after reset or
// on request so an unprogrammed trie always faults (CTRL valid bit = 0).
// Optional feature macro: CV32E41S_RPM_PARITY_EN (per-word even parity).
module cv32e41s_rpm_responder #(
  parameter int DEPTH          = 64,
  parameter bit SCRUB_ON_RESET = 1'b1
) (
  input logic                      clk,
  input logic                      rst,
  cv32e41s_rpm_responder_if.slave  bus
);
  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic {
    ST_SCRUB = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t           r_state;
  logic [IDX_W-1:0] r_scrub_cnt;
  logic             r_rvalid;
  logic [31:0]      r_rdata_b0;
  logic [31:0]      r_rdata_b1;
  logic             r_addr_err;
  logic             r_parity_err;

  logic [31:0]      r_mem_b0 [DEPTH];
  logic [31:0]      r_mem_b1 [DEPTH];

  logic [IDX_W-1:0] w_rd_idx;
  logic             w_rd_oor;
  logic             w_wr_gnt;
  logic             w_wr_do;
  logic             w_fwd_b0;
  logic             w_fwd_b1;
  logic [31:0]      w_rd_b0;
  logic [31:0]      w_rd_b1;
  logic             w_perr;
  logic             w_unused;

  // Byte-offset bits of the walker address carry no information.
  assign w_unused = ^bus.imp_addr_i[1:0];

  assign w_rd_idx = bus.imp_addr_i[IDX_W+1:2];
  assign w_rd_oor = (|bus.imp_addr_i[31:IDX_W+2]) ||
                    (32'(w_rd_idx) >= 32'(DEPTH));

  assign w_wr_gnt = bus.wr_req_i & (r_state == ST_READY);
  // Out-of-range writes are granted but dropped; nothing lands during reset.
  assign w_wr_do  = w_wr_gnt & (32'(bus.wr_idx_i) < 32'(DEPTH)) & ~rst;

  // Write-first: a same-cycle write to the read entry is forwarded.
  assign w_fwd_b0 = w_wr_do & ~bus.wr_bank_i & (bus.wr_idx_i == w_rd_idx);
  assign w_fwd_b1 = w_wr_do &  bus.wr_bank_i & (bus.wr_idx_i == w_rd_idx);
  assign w_rd_b0  = w_fwd_b0 ? bus.wr_data_i : r_mem_b0[w_rd_idx];
  assign w_rd_b1  = w_fwd_b1 ? bus.wr_data_i : r_mem_b1[w_rd_idx];

`ifdef CV32E41S_RPM_PARITY_EN
  logic r_par_b0 [DEPTH];
  logic r_par_b1 [DEPTH];

  // A forwarded word is fresh, so only the stored (non-forwarded) bank is checked.
  assign w_perr = ~w_rd_oor &
                  ((~w_fwd_b0 & ((^r_mem_b0[w_rd_idx]) != r_par_b0[w_rd_idx])) |
                   (~w_fwd_b1 & ((^r_mem_b1[w_rd_idx]) != r_par_b1[w_rd_idx])));

  // Parity bits follow every array write, scrub writes included.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (r_state == ST_SCRUB) begin
        r_par_b0[r_scrub_cnt] <= 1'b0;
        r_par_b1[r_scrub_cnt] <= 1'b0;
      end else if (w_wr_do) begin
        if (bus.wr_bank_i) r_par_b1[bus.wr_idx_i] <= ^bus.wr_data_i;
        else               r_par_b0[bus.wr_idx_i] <= ^bus.wr_data_i;
      end
    end
  end
`else
  assign w_perr = 1'b0;
`endif

  // Entry array: scrub zeroes one entry per cycle, READY takes granted writes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (r_state == ST_SCRUB) begin
        r_mem_b0[r_scrub_cnt] <= '0;
        r_mem_b1[r_scrub_cnt] <= '0;
      end else if (w_wr_do) begin
        if (bus.wr_bank_i) r_mem_b1[bus.wr_idx_i] <= bus.wr_data_i;
        else               r_mem_b0[bus.wr_idx_i] <= bus.wr_data_i;
      end
    end
  end

  // Control FSM with registered read-response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= SCRUB_ON_RESET ? ST_SCRUB : ST_READY;
      r_scrub_cnt  <= '0;
      r_rvalid     <= 1'b0;
      r_rdata_b0   <= '0;
      r_rdata_b1   <= '0;
      r_addr_err   <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      case (r_state)
        ST_SCRUB: begin
          r_rvalid     <= 1'b0;
          r_rdata_b0   <= '0;
          r_rdata_b1   <= '0;
          r_addr_err   <= 1'b0;
          r_parity_err <= 1'b0;
          if (r_scrub_cnt == IDX_W'(DEPTH - 1)) begin
            r_scrub_cnt <= '0;
            r_state     <= ST_READY;
          end else begin
            r_scrub_cnt <= r_scrub_cnt + 1'b1;
          end
        end
        ST_READY: begin
          if (bus.scrub_req_i) begin
            // Any read in this cycle would answer inside SCRUB, so drop it.
            r_state      <= ST_SCRUB;
            r_scrub_cnt  <= '0;
            r_rvalid     <= 1'b0;
            r_rdata_b0   <= '0;
            r_rdata_b1   <= '0;
            r_addr_err   <= 1'b0;
            r_parity_err <= 1'b0;
          end else if (bus.imp_req_i) begin
            r_rvalid     <= 1'b1;
            r_addr_err   <= w_rd_oor;
            r_parity_err <= w_perr;
            if (w_rd_oor || w_perr) begin
              r_rdata_b0 <= '0;
              r_rdata_b1 <= '0;
            end else begin
              r_rdata_b0 <= w_rd_b0;
              r_rdata_b1 <= w_rd_b1;
            end
          end else begin
            // Data holds between reads; only the strobes drop.
            r_rvalid     <= 1'b0;
            r_addr_err   <= 1'b0;
            r_parity_err <= 1'b0;
          end
        end
        default: r_state <= ST_SCRUB;
      endcase
    end
  end

  assign bus.imp_rvalid_o   = r_rvalid;
  assign bus.imp_rdata_b0_o = r_rdata_b0;
  assign bus.imp_rdata_b1_o = r_rdata_b1;
  assign bus.imp_addr_err_o = r_addr_err;
  assign bus.wr_gnt_o       = w_wr_gnt;
  assign bus.busy_o         = (r_state == ST_SCRUB);
  assign bus.dbg_state_o    = r_state;
`ifdef CV32E41S_RPM_PARITY_EN
  assign bus.parity_err_o   = r_parity_err;
`else
  assign bus.parity_err_o   = 1'b0;
`endif

endmodule

// File: tb/tb_cv32e41s_rpm_responder.sv
// Directed bench for cv32e41s_rpm_responder (DEPTH = 64, scrub on reset).
module tb_cv32e41s_rpm_responder;
  localparam int DEPTH = 64;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  cv32e41s_rpm_responder_if #(.DEPTH(DEPTH)) bus_if ();

  cv32e41s_rpm_responder #(.DEPTH(DEPTH), .SCRUB_ON_RESET(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one cycle; outputs are then sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus_if.imp_req_i   = 1'b0;
    bus_if.imp_addr_i  = '0;
    bus_if.wr_req_i    = 1'b0;
    bus_if.wr_idx_i    = '0;
    bus_if.wr_bank_i   = 1'b0;
    bus_if.wr_data_i   = '0;
    bus_if.scrub_req_i = 1'b0;
  endtask

  // Counts busy cycles (bounded) while checking that SCRUB blocks writes/reads.
  task automatic count_busy(input string tag, output int n);
    n = 0;
    while (bus_if.busy_o && n < 200) begin
      if (bus_if.wr_gnt_o !== 1'b0 || bus_if.imp_rvalid_o !== 1'b0)
        check({tag, "_scrub_blocks"}, {30'd0, bus_if.wr_gnt_o, bus_if.imp_rvalid_o}, 32'd0);
      n++;
      tick();
    end
  endtask

  task automatic do_write(input int idx, input logic bank, input logic [31:0] data);
    bus_if.wr_req_i  = 1'b1;
    bus_if.wr_idx_i  = 6'(idx);
    bus_if.wr_bank_i = bank;
    bus_if.wr_data_i = data;
    #1;
    check("wr_gnt", {31'd0, bus_if.wr_gnt_o}, 32'd1);
    tick();
    bus_if.wr_req_i = 1'b0;
  endtask

  task automatic check_read(input string tag, input logic [31:0] b0, input logic [31:0] b1,
                            input logic err);
    check({tag, "_rvalid"}, {31'd0, bus_if.imp_rvalid_o}, 32'd1);
    check({tag, "_b0"}, bus_if.imp_rdata_b0_o, b0);
    check({tag, "_b1"}, bus_if.imp_rdata_b1_o, b1);
    check({tag, "_err"}, {31'd0, bus_if.imp_addr_err_o}, {31'd0, err});
    check({tag, "_perr"}, {31'd0, bus_if.parity_err_o}, 32'd0);
  endtask

  initial begin
    int n;
    n_checks = 0;
    n_fail   = 0;
    idle_inputs();
    rst = 1'b1;
    // Write request held through reset and scrub must never be granted.
    bus_if.wr_req_i  = 1'b1;
    bus_if.wr_idx_i  = 6'd5;
    bus_if.wr_data_i = 32'hDEAD_BEEF;
    bus_if.imp_req_i  = 1'b1;
    bus_if.imp_addr_i = 32'h14;
    tick(); tick(); tick();

    // Reset values
    check("rst_rvalid", {31'd0, bus_if.imp_rvalid_o}, 32'd0);
    check("rst_b0", bus_if.imp_rdata_b0_o, 32'd0);
    check("rst_b1", bus_if.imp_rdata_b1_o, 32'd0);
    check("rst_err", {31'd0, bus_if.imp_addr_err_o}, 32'd0);
    check("rst_gnt", {31'd0, bus_if.wr_gnt_o}, 32'd0);
    check("rst_busy", {31'd0, bus_if.busy_o}, 32'd1);
    check("rst_perr", {31'd0, bus_if.parity_err_o}, 32'd0);
    check("rst_state", {31'd0, bus_if.dbg_state_o}, 32'd0);

    // Initial scrub: exactly DEPTH busy cycles
    rst = 1'b0;
    count_busy("init", n);
    bus_if.wr_req_i = 1'b0;
    check("init_busy_cycles", n, DEPTH);
    check("ready_state", {31'd0, bus_if.dbg_state_o}, 32'd1);
    // Read request in last scrub cycle was dropped
    check("last_scrub_read_dropped", {31'd0, bus_if.imp_rvalid_o}, 32'd0);
    tick();
    check_read("idx5_after_scrub", 32'd0, 32'd0, 1'b0);
    bus_if.imp_req_i = 1'b0;
    tick();
    check("idle_rvalid", {31'd0, bus_if.imp_rvalid_o}, 32'd0);

    // Program entry 3 and read it back, then back-to-back read of entry 5
    do_write(3, 1'b0, 32'h0004_0F01);
    do_write(3, 1'b1, 32'h1234_5678);
    bus_if.imp_req_i  = 1'b1;
    bus_if.imp_addr_i = 32'h0C;
    tick();
    check_read("idx3", 32'h0004_0F01, 32'h1234_5678, 1'b0);
    bus_if.imp_addr_i = 32'h14;
    tick();
    check_read("idx5_b2b", 32'd0, 32'd0, 1'b0);
    bus_if.imp_req_i = 1'b0;

    // Write-first on same-cycle read/write
    do_write(7, 1'b0, 32'h1111_1111);
    do_write(7, 1'b1, 32'hCAFE_F00D);
    bus_if.imp_req_i  = 1'b1;
    bus_if.imp_addr_i = 32'h1C;
    bus_if.wr_req_i   = 1'b1;
    bus_if.wr_idx_i   = 6'd7;
    bus_if.wr_bank_i  = 1'b0;
    bus_if.wr_data_i  = 32'hAAAA_5555;
    tick();
    bus_if.wr_req_i  = 1'b0;
    bus_if.imp_req_i = 1'b0;
    check_read("wr_first", 32'hAAAA_5555, 32'hCAFE_F00D, 1'b0);
    tick();
    // rdata holds while idle
    check("hold_rvalid", {31'd0, bus_if.imp_rvalid_o}, 32'd0);
    check("hold_b0", bus_if.imp_rdata_b0_o, 32'hAAAA_5555);
    check("hold_b1", bus_if.imp_rdata_b1_o, 32'hCAFE_F00D);

    // Out-of-range read, then a read with nonzero low address bits
    bus_if.imp_req_i  = 1'b1;
    bus_if.imp_addr_i = 32'h400;
    tick();
    check_read("oor_400", 32'd0, 32'd0, 1'b1);
    bus_if.imp_addr_i = 32'h8000_000C;
    tick();
    check_read("oor_hi", 32'd0, 32'd0, 1'b1);
    bus_if.imp_addr_i = 32'h0F;
    tick();
    check_read("idx3_lowbits", 32'h0004_0F01, 32'h1234_5678, 1'b0);
    bus_if.imp_req_i = 1'b0;

    // Requested scrub clears everything
    bus_if.scrub_req_i = 1'b1;
    tick();
    bus_if.scrub_req_i = 1'b0;
    count_busy("req", n);
    check("req_busy_cycles", n, DEPTH);
    bus_if.imp_req_i = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      bus_if.imp_addr_i = 32'(i * 4);
      tick();
      if (bus_if.imp_rdata_b0_o !== 32'd0 || bus_if.imp_rdata_b1_o !== 32'd0 ||
          bus_if.imp_rvalid_o !== 1'b1)
        check($sformatf("scrubbed_%0d", i),
              bus_if.imp_rdata_b0_o | bus_if.imp_rdata_b1_o | {31'd0, ~bus_if.imp_rvalid_o},
              32'd0);
      else
        check($sformatf("scrubbed_%0d", i), bus_if.imp_rdata_b0_o | bus_if.imp_rdata_b1_o, 32'd0);
    end
    bus_if.imp_req_i = 1'b0;

    // Reset at scrub cycle 10 restarts a full scrub
    do_write(3, 1'b0, 32'h0000_0055);
    bus_if.scrub_req_i = 1'b1;
    tick();
    bus_if.scrub_req_i = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("mid_scrub_busy", {31'd0, bus_if.busy_o}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst2_busy", {31'd0, bus_if.busy_o}, 32'd1);
    check("rst2_rvalid", {31'd0, bus_if.imp_rvalid_o}, 32'd0);
    count_busy("rst2", n);
    check("rst2_busy_cycles", n, DEPTH);
    bus_if.imp_req_i  = 1'b1;
    bus_if.imp_addr_i = 32'h0C;
    tick();
    check_read("idx3_after_rst2", 32'd0, 32'd0, 1'b0);
    bus_if.imp_req_i = 1'b0;

`ifdef CV32E41S_RPM_PARITY_EN
    // Corrupted stored parity on entry 2 zeroes the data and flags the error
    do_write(2, 1'b0, 32'h0000_0001);
    do_write(2, 1'b1, 32'h0000_0003);
    dut.r_par_b0[2] = ~dut.r_par_b0[2];
    bus_if.imp_req_i  = 1'b1;
    bus_if.imp_addr_i = 32'h08;
    tick();
    bus_if.imp_req_i = 1'b0;
    check("par_rvalid", {31'd0, bus_if.imp_rvalid_o}, 32'd1);
    check("par_b0", bus_if.imp_rdata_b0_o, 32'd0);
    check("par_b1", bus_if.imp_rdata_b1_o, 32'd0);
    check("par_err", {31'd0, bus_if.parity_err_o}, 32'd1);
`endif

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
